zebra_decision_filter: RTL and testbench
========================================

# zebra_decision_filter

Temporal filter placed directly downstream of the zebra-crossing pattern recognition stage. Each frame, that stage reports a detection with `detection_valid`, `crossing_detected` and `long_run_count`; this block consumes those per-frame reports. It applies confirm/release hysteresis to produce a stable `crossing_present` level, and issues enter/exit events over a valid/ready handshake to the vehicle controller. A watchdog forces the decision to absent when frame reports stop arriving.

## Interface
Parameters:
- `COUNT_W`, 8, width of `long_run_count`
- `MIN_RUNS`, 3, minimum `det_run_count` for a frame to count as a hit
- `CONFIRM_FRAMES`, 3, consecutive hit frames to enter PRESENT (≥1)
- `RELEASE_FRAMES`, 5, consecutive miss frames to leave PRESENT (≥1)
- `STALE_CYCLES`, 2_000_000, clock cycles without `det_valid` before the stale condition is declared

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  system clock
- `rst`  input  1  asynchronous, active-high reset
- `det_valid`  input  1  one-cycle pulse, frame report present
- `det_zebra`  input  1  detector verdict for the frame
- `det_run_count`  input  COUNT_W  long-run count for the frame
- `crossing_present`  output  1  filtered decision level
- `evt_valid`  output  1  event pending
- `evt_ready`  input  1  consumer accepts event
- `evt_enter`  output  1  1 = ENTER event, 0 = EXIT event
- `evt_overrun`  output  1  sticky: an unaccepted event was overwritten
- `stale`  output  1  watchdog expired
- `frame_count`  output  16  number of reports received, wraps 0xFFFF→0

## Operation
- Hit = `det_zebra && det_run_count >= MIN_RUNS` (unsigned compare). Miss = any other reported frame.
- FSM states: ABSENT, CONFIRMING, PRESENT, RELEASING. It advances only on `det_valid`.
- ABSENT:
  - On a hit, go to CONFIRMING with `hit_cnt=1`.
  - If `CONFIRM_FRAMES==1`, go straight to PRESENT and raise ENTER.
- CONFIRMING:
  - On a hit, `hit_cnt++`. When `hit_cnt==CONFIRM_FRAMES`, go to PRESENT and raise ENTER.
  - On a miss, go to ABSENT and clear `hit_cnt`.
- PRESENT:
  - On a miss, go to RELEASING with `miss_cnt=1`.
  - If `RELEASE_FRAMES==1`, go straight to ABSENT and raise EXIT.
- RELEASING:
  - On a miss, `miss_cnt++`. When `miss_cnt==RELEASE_FRAMES`, go to ABSENT and raise EXIT.
  - On a hit, go to PRESENT and clear `miss_cnt`.
- `crossing_present` = 1 in PRESENT and RELEASING only.
- Counters saturate at their terminal value and never wrap.
- Event register (one entry):
  - A raised event loads `evt_enter` and sets `evt_valid`.
  - The event is consumed when `evt_valid && evt_ready`.
  - If an event is raised while `evt_valid=1` and `evt_ready=0`, the new event overwrites the pending one and `evt_overrun` is set. `evt_overrun` clears only on reset.
  - If an event is raised in the same cycle that the pending event is accepted, the new event loads and no overrun is flagged.
- `frame_count` increments on every `det_valid`.

## Timing
- Reset values: `crossing_present=0`, `evt_valid=0`, `evt_enter=0`, `evt_overrun=0`, `stale=0`, `frame_count=0`, FSM=ABSENT, all counters 0.
- All outputs are registered.
- `det_valid` is sampled on edge N. The FSM, `crossing_present`, `evt_valid` and `frame_count` update after that edge and are visible in cycle N+1 (1-cycle latency).
- `evt_valid` and `evt_enter` hold stable until accepted. `evt_valid` drops in the cycle after acceptance unless a new event loads.
- `det_valid` pulses closer together than 1 cycle cannot occur. Back-to-back pulses are each processed.
- `rst` asserted mid-episode returns every register to its reset value asynchronously. No EXIT event is emitted.

## Configuration
- Macro `ZEBRA_DECISION_WATCHDOG_EN` compiles the watchdog in or out.
- Defined:
  - A cycle counter clears on every `det_valid` and increments otherwise, saturating at `STALE_CYCLES`.
  - On reaching `STALE_CYCLES`, `stale` goes to 1 and the FSM is forced to ABSENT with its counters cleared.
  - If the FSM was in PRESENT or RELEASING, an EXIT event is raised.
  - `stale` clears in the cycle after the next `det_valid`. That report is processed normally from ABSENT.
- Undefined: `stale` is tied to 0, no watchdog counter exists, and the FSM depends only on reports.

## Structure
- Package `zebra_pkg`:
  - FSM state enum (`ZD_ABSENT`, `ZD_CONFIRMING`, `ZD_PRESENT`, `ZD_RELEASING`)
  - event-type constants `EVT_ENTER=1'b1`, `EVT_EXIT=1'b0`
  - shared `COUNT_W` default
- Sub-module `frame_watchdog`: the saturating timeout counter with `kick` and `expired` ports, instantiated only under the macro.
- Hit compare, FSM and event register live in the top module.

## Test plan
- Three hit reports with `det_run_count=4` → `crossing_present` rises 1 cycle after the 3rd report, with `evt_valid=1` and `evt_enter=1`.
- Hit, hit, miss, hit (count 3) → no ENTER event; the FSM is back in CONFIRMING with `hit_cnt=1`.
- `det_zebra=1` with `det_run_count=2` on every frame → never PRESENT. `frame_count` advances on each report.
- From PRESENT: four misses, one hit, then five misses → EXIT raised only after the final 5th consecutive miss. `crossing_present=0` thereafter.
- ENTER left pending with `evt_ready=0`, then EXIT raised → `evt_enter=0` and `evt_overrun=1`. Raising EXIT in the same cycle that ENTER is accepted → `evt_overrun` stays 0.
- Watchdog build with `STALE_CYCLES=100`: in PRESENT, no reports for 100 cycles → `stale=1`, `crossing_present=0` and an EXIT event. The next report clears `stale`.

Source files
------------

// File: rtl/zebra_pkg.sv
// zebra_pkg: shared state encoding, event codes and default widths for the zebra decision filter.
package zebra_pkg;
  localparam int ZD_COUNT_W = 8;
  typedef enum logic [1:0] {ZD_ABSENT, ZD_CONFIRMING, ZD_PRESENT, ZD_RELEASING} zd_state_t;
  localparam logic EVT_ENTER = 1'b1;
  localparam logic EVT_EXIT  = 1'b0;
endpackage

// File: rtl/frame_watchdog.sv
// frame_watchdog: saturating idle-cycle counter; expired holds while the count sits at STALE_CYCLES.
module frame_watchdog #(
  parameter int unsigned STALE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);
  localparam int W = $clog2(STALE_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(STALE_CYCLES);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (kick) r_cnt <= '0;
    else if (r_cnt != LIMIT) r_cnt <= r_cnt + 1'b1;
  assign expired = (r_cnt == LIMIT);
endmodule

// File: rtl/zebra_decision_filter.sv
// zebra_decision_filter: confirm/release hysteresis over per-frame zebra reports with enter/exit events.
// Define ZEBRA_DECISION_WATCHDOG_EN to compile in the stale-report watchdog.
module zebra_decision_filter
  import zebra_pkg::*;
#(
  parameter int          COUNT_W        = ZD_COUNT_W,
  parameter int          MIN_RUNS       = 3,
  parameter int          CONFIRM_FRAMES = 3,
  parameter int          RELEASE_FRAMES = 5,
  parameter int unsigned STALE_CYCLES   = 2_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               det_valid,
  input  logic               det_zebra,
  input  logic [COUNT_W-1:0] det_run_count,
  output logic               crossing_present,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic               evt_enter,
  output logic               evt_overrun,
  output logic               stale,
  output logic [15:0]        frame_count
);
  localparam int HW = $clog2(CONFIRM_FRAMES + 1);
  localparam int MW = $clog2(RELEASE_FRAMES + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(CONFIRM_FRAMES - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(RELEASE_FRAMES - 1);
  localparam logic [COUNT_W-1:0] MIN_R = COUNT_W'(MIN_RUNS);
  zd_state_t r_state;
  logic [HW-1:0] r_hit_cnt;
  logic [MW-1:0] r_miss_cnt;
  logic r_present, r_evt_valid, r_evt_enter, r_evt_overrun;
  logic [15:0] r_frame_count;
  logic w_hit, w_trip, w_enter, w_exit, w_raise;
`ifdef ZEBRA_DECISION_WATCHDOG_EN
  logic w_expired, r_stale;
  frame_watchdog #(.STALE_CYCLES(STALE_CYCLES)) u_watchdog (
    .clk(clk), .rst(rst), .kick(det_valid), .expired(w_expired)
  );
  // a report arriving on the expiry cycle wins; the trip fires once per stale episode
  assign w_trip = w_expired && !r_stale && !det_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_stale <= 1'b0;
    else if (w_trip) r_stale <= 1'b1;
    else if (det_valid) r_stale <= 1'b0;
  assign stale = r_stale;
`else
  assign w_trip = 1'b0;
  assign stale  = 1'b0;
`endif
  always_comb begin
    w_hit   = det_zebra && (det_run_count >= MIN_R);
    w_enter = det_valid && !w_trip && w_hit &&
              ((r_state == ZD_ABSENT && CONFIRM_FRAMES == 1) ||
               (r_state == ZD_CONFIRMING && r_hit_cnt == HIT_LAST));
    w_exit  = w_trip ? r_present :
              det_valid && !w_hit &&
              ((r_state == ZD_PRESENT && RELEASE_FRAMES == 1) ||
               (r_state == ZD_RELEASING && r_miss_cnt == MISS_LAST));
    w_raise = w_enter || w_exit;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst || w_trip) begin
      r_state    <= ZD_ABSENT;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_present  <= 1'b0;
    end else if (det_valid) begin
      if (r_state == ZD_ABSENT || r_state == ZD_CONFIRMING) begin
        r_state   <= !w_hit ? ZD_ABSENT : w_enter ? ZD_PRESENT : ZD_CONFIRMING;
        r_hit_cnt <= (w_hit && !w_enter) ? r_hit_cnt + 1'b1 : '0;
        r_present <= w_enter;
      end else begin
        r_state    <= w_hit ? ZD_PRESENT : w_exit ? ZD_ABSENT : ZD_RELEASING;
        r_miss_cnt <= (!w_hit && !w_exit) ? r_miss_cnt + 1'b1 : '0;
        r_present  <= !w_exit;
      end
    end
  // single-entry event slot: a new event always wins, overrun only if the old one was not taken
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_evt_valid   <= 1'b0;
      r_evt_enter   <= 1'b0;
      r_evt_overrun <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (det_valid) r_frame_count <= r_frame_count + 1'b1;
      if (w_raise) begin
        r_evt_valid <= 1'b1;
        r_evt_enter <= w_enter ? EVT_ENTER : EVT_EXIT;
        if (r_evt_valid && !evt_ready) r_evt_overrun <= 1'b1;
      end else if (evt_ready) r_evt_valid <= 1'b0;
    end
  assign crossing_present = r_present;
  assign evt_valid        = r_evt_valid;
  assign evt_enter        = r_evt_enter;
  assign evt_overrun      = r_evt_overrun;
  assign frame_count      = r_frame_count;
endmodule

// File: tb/tb_zebra_decision_filter.sv
// tb_zebra_decision_filter: directed and random report streams checked against a streak-based hysteresis model.
module tb_zebra_decision_filter;
  localparam int CONF = 3, REL = 5, MINR = 3, STALE_N = 100;
`ifdef ZEBRA_DECISION_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic det_valid = 1'b0, det_zebra = 1'b0, evt_ready = 1'b0;
  logic [7:0] det_run_count = '0;
  logic crossing_present, evt_valid, evt_enter, evt_overrun, stale;
  logic [15:0] frame_count;
  int n_vec = 0, n_err = 0;
  bit m_present, m_ev_v, m_ev_e, m_ovr, m_stale;
  int streak, idle;
  logic [15:0] m_fc;

  zebra_decision_filter #(
    .COUNT_W(8), .MIN_RUNS(MINR), .CONFIRM_FRAMES(CONF), .RELEASE_FRAMES(REL), .STALE_CYCLES(STALE_N)
  ) dut (
    .clk(clk), .rst(rst), .det_valid(det_valid), .det_zebra(det_zebra), .det_run_count(det_run_count),
    .crossing_present(crossing_present), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_enter(evt_enter), .evt_overrun(evt_overrun), .stale(stale), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_present = 0; m_ev_v = 0; m_ev_e = 0; m_ovr = 0; m_stale = 0;
    streak = 0; idle = 0; m_fc = '0;
  endtask

  // decision flips after a streak of opposing verdicts; any agreeing verdict restarts the streak
  task automatic model(input bit v, input bit z, input int c, input bit r);
    bit hit, raise, r_enter, trip;
    hit = z && c >= MINR;
    raise = 0; r_enter = 0;
    trip = WD && idle >= STALE_N && !m_stale && !v;
    if (trip) begin
      m_stale = 1;
      if (m_present) raise = 1;
      m_present = 0; streak = 0;
    end else if (v) begin
      m_stale = 0;
      if (hit != m_present) streak++; else streak = 0;
      if (!m_present && streak == CONF) begin m_present = 1; streak = 0; raise = 1; r_enter = 1; end
      else if (m_present && streak == REL) begin m_present = 0; streak = 0; raise = 1; end
    end
    if (raise) begin
      if (m_ev_v && !r) m_ovr = 1;
      m_ev_v = 1; m_ev_e = r_enter;
    end else if (r) m_ev_v = 0;
    if (v) m_fc++;
    idle = v ? 0 : (idle < STALE_N ? idle + 1 : idle);
  endtask

  task automatic compare_all();
    check("present", crossing_present, m_present);
    check("evt_valid", evt_valid, m_ev_v);
    check("evt_enter", evt_enter, m_ev_e);
    check("overrun", evt_overrun, m_ovr);
    check("stale", stale, m_stale);
    check("frame_count", frame_count, m_fc);
  endtask

  // entered and left at a negedge
  task automatic step(input bit v, input bit z, input int c, input bit r);
    det_valid = v; det_zebra = z; det_run_count = 8'(c); evt_ready = r;
    @(posedge clk);
    model(v, z, c, r);
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic report(input bit z, input int c, input bit r);
    repeat ($urandom_range(0, 2)) step(0, $urandom % 2, $urandom_range(0, 7), r);
    step(1, z, c, r);
  endtask

  task automatic hits(input int n, input bit r);
    repeat (n) report(1, 4, r);
  endtask

  task automatic misses(input int n, input bit r);
    repeat (n) report($urandom % 2, ($urandom % 2) ? 0 : 2, r);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("areset_present", crossing_present, 0);
    check("areset_evt_valid", evt_valid, 0);
    check("areset_overrun", evt_overrun, 0);
    check("areset_frame_count", frame_count, 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_present", crossing_present, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_enter", evt_enter, 0);
    check("rst_overrun", evt_overrun, 0);
    check("rst_stale", stale, 0);
    check("rst_frame_count", frame_count, 0);
    rst = 1'b0;
    hits(3, 0);
    check("enter_present", crossing_present, 1);
    check("enter_evt", {evt_valid, evt_enter}, 2'b11);
    step(0, 0, 0, 1);
    misses(4, 0);
    report(1, 3, 0);
    misses(4, 0);
    check("release_hold", crossing_present, 1);
    misses(1, 0);
    check("exit_present", crossing_present, 0);
    check("exit_evt", {evt_valid, evt_enter}, 2'b10);
    step(0, 0, 0, 1);
    report(1, 3, 1); report(1, 3, 1); report(0, 9, 1); report(1, 3, 1);
    report(1, 3, 1);
    check("restart_not_yet", crossing_present, 0);
    report(1, 3, 1);
    check("restart_present", crossing_present, 1);
    misses(5, 1);
    repeat (6) report(1, 2, 1);
    check("low_runs_absent", crossing_present, 0);
    hits(3, 0);
    misses(5, 0);
    check("overrun_evt", {evt_valid, evt_enter, evt_overrun}, 3'b101);
    async_reset();
    hits(3, 0);
    misses(4, 0);
    step(1, 0, 0, 1);
    check("accept_same_cycle", {evt_valid, evt_enter, evt_overrun}, 3'b100);
    for (int i = 0; i < 1500; i++)
      step($urandom % 2, ($urandom % 4) != 0, $urandom_range(0, 6), ($urandom % 4) == 0);
    step(0, 0, 0, 1);
    misses(5, 1);
    hits(3, 1);
    repeat (STALE_N + 10) step(0, 0, 0, 0);
`ifdef ZEBRA_DECISION_WATCHDOG_EN
    check("wd_stale", stale, 1);
    check("wd_present", crossing_present, 0);
    check("wd_exit_evt", {evt_valid, evt_enter}, 2'b10);
    step(1, 0, 0, 1);
    check("wd_stale_clear", stale, 0);
`else
    check("no_wd_present", crossing_present, 1);
    step(1, 0, 0, 1);
`endif
    hits(3, 1);
    async_reset();
    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
